// File: rtl/min_max_tracker_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// mmt_pkg : shared types, defaults and helpers for min_max_tracker
// Revision 1.0
// ----------------------------------------------------------------
package mmt_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Returns {blocked, next}: next is cnt+1 unless cnt already equals max_v.
  function automatic logic [32:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_v);
    if (cnt == max_v) return {1'b1, cnt};
    return {1'b0, cnt + 32'd1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/min_max_tracker_if.sv
`default_nettype none
// ----------------------------------------------------------------
// min_max_tracker_if : sample-in and result-out handshakes
// Revision 1.0
// ----------------------------------------------------------------
interface min_max_tracker_if
  import mmt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
  logic [CNT_W-1:0] count_out;
  logic             cnt_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, min_out, max_out, count_out, cnt_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, min_out, max_out, count_out, cnt_sat
  );
endinterface
`default_nettype wire

// File: rtl/min_max_tracker_cmp_flags.sv
`default_nettype none
// ----------------------------------------------------------------
// cmp_flags : signed less/eq/greater built like the ALU comparator
// Revision 1.0
// ----------------------------------------------------------------
module cmp_flags
  import mmt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             less_o,
  output logic             eq_o,
  output logic             greater_o
);
  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_xor;
  logic             w_carry;

  assign w_nb  = ~b_i;
  assign w_xor = a_i ^ b_i;

  // Carry chain of a + ~b + 1; only the carry-out is needed.
  always_comb begin
    w_carry = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      w_carry = (a_i[k] & w_nb[k]) | (w_carry & (a_i[k] ^ w_nb[k]));
    end
  end

  assign eq_o      = (w_xor == '0);
  assign less_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) ? a_i[WIDTH-1] : ~w_carry;
  assign greater_o = ~(less_o | eq_o);
endmodule
`default_nettype wire

// File: rtl/min_max_tracker.sv
`default_nettype none
// ----------------------------------------------------------------
// min_max_tracker : streaming signed min/max/count over one frame
// Revision 1.0
// ----------------------------------------------------------------
module min_max_tracker
  import mmt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  min_max_tracker_if.slave   bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_min_less, w_min_eq, w_min_gt;
  logic             w_max_less, w_max_eq, w_max_gt;
  logic [32:0]      w_inc;
  logic             w_unused;

  cmp_flags #(.WIDTH(WIDTH)) u_cmp_min (
    .a_i(bus.in_data), .b_i(min_q),
    .less_o(w_min_less), .eq_o(w_min_eq), .greater_o(w_min_gt)
  );

  cmp_flags #(.WIDTH(WIDTH)) u_cmp_max (
    .a_i(bus.in_data), .b_i(max_q),
    .less_o(w_max_less), .eq_o(w_max_eq), .greater_o(w_max_gt)
  );

  assign w_inc    = sat_inc(32'(cnt_q), 32'((64'd1 << CNT_W) - 64'd1));
  assign w_unused = ^{w_inc[31:CNT_W], w_min_eq, w_min_gt, w_max_eq, w_max_less};
  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (w_accept) state_d = bus.in_last ? DONE : ACCUM;
      ACCUM:   if (w_accept && bus.in_last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    w_in_ready  = rst_n & (state_q != DONE);
    w_out_valid = (state_q == DONE);
  end

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (w_accept && state_q == EMPTY) begin
      min_d = bus.in_data;
      max_d = bus.in_data;
      cnt_d = CNT_W'(1);
      sat_d = 1'b0;
    end else if (w_accept && state_q == ACCUM) begin
      if (w_min_less) min_d = bus.in_data;
      if (w_max_gt)   max_d = bus.in_data;
      cnt_d = w_inc[CNT_W-1:0];
      sat_d = sat_q | w_inc[32];
    end else if (w_out_valid && bus.out_ready) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.min_out   = min_q;
  assign bus.max_out   = max_q;
  assign bus.count_out = cnt_q;
  assign bus.cnt_sat   = sat_q;
endmodule
`default_nettype wire

// File: tb/tb_min_max_tracker.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_min_max_tracker : directed self-checking bench for min_max_tracker
// Revision 1.0
// ----------------------------------------------------------------
module tb_min_max_tracker;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  min_max_tracker_if #(.WIDTH(4), .CNT_W(4)) bus ();

  min_max_tracker #(.WIDTH(4), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  task automatic push(input logic [3:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if ({bus.min_out, bus.max_out, bus.count_out, bus.cnt_sat} !== 13'h0) begin errors++; $display("FAIL reset_regs got=%h/%h/%0d/%b want=0/0/0/0", bus.min_out, bus.max_out, bus.count_out, bus.cnt_sat); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_mixed();
    push(4'h3, 1'b0); push(4'hE, 1'b0); push(4'h7, 1'b0); push(4'h8, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mixed_early_valid got=%b want=0", bus.out_valid); end
    push(4'h0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mixed_out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mixed_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.min_out !== 4'h8) begin errors++; $display("FAIL mixed_min got=%h want=8", bus.min_out); end
    checks++; if (bus.max_out !== 4'h7) begin errors++; $display("FAIL mixed_max got=%h want=7", bus.max_out); end
    checks++; if (bus.count_out !== 4'd5) begin errors++; $display("FAIL mixed_count got=%0d want=5", bus.count_out); end
    checks++; if (bus.cnt_sat !== 1'b0) begin errors++; $display("FAIL mixed_sat got=%b want=0", bus.cnt_sat); end
    take();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mixed_after_take got=v%b r%b want=v0 r1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL mixed_count_clear got=%0d want=0", bus.count_out); end
    checks++; if (bus.min_out !== 4'h8 || bus.max_out !== 4'h7) begin errors++; $display("FAIL mixed_hold_in_empty got=%h/%h want=8/7", bus.min_out, bus.max_out); end
  endtask

  task automatic test_single();
    push(4'hF, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.min_out !== 4'hF || bus.max_out !== 4'hF) begin errors++; $display("FAIL single_minmax got=%h/%h want=f/f", bus.min_out, bus.max_out); end
    checks++; if (bus.count_out !== 4'd1) begin errors++; $display("FAIL single_count got=%0d want=1", bus.count_out); end
    take();
  endtask

  task automatic test_equal();
    push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h5, 1'b1);
    checks++; if (bus.min_out !== 4'h5 || bus.max_out !== 4'h5) begin errors++; $display("FAIL equal_minmax got=%h/%h want=5/5", bus.min_out, bus.max_out); end
    checks++; if (bus.count_out !== 4'd3) begin errors++; $display("FAIL equal_count got=%0d want=3", bus.count_out); end
    take();
    push(4'h7, 1'b0); push(4'h8, 1'b1);
    checks++; if (bus.min_out !== 4'h8 || bus.max_out !== 4'h7) begin errors++; $display("FAIL sign_boundary got=%h/%h want=8/7", bus.min_out, bus.max_out); end
    checks++; if (bus.count_out !== 4'd2) begin errors++; $display("FAIL sign_boundary_count got=%0d want=2", bus.count_out); end
    take();
  endtask

  task automatic test_backpressure();
    push(4'h1, 1'b0); push(4'h6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 4'hC; bus.in_last = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hs[%0d] got=v%b r%b want=v1 r0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.min_out !== 4'h1 || bus.max_out !== 4'h6 || bus.count_out !== 4'd2) begin errors++; $display("FAIL bp_hold[%0d] got=%h/%h/%0d want=1/6/2", i, bus.min_out, bus.max_out, bus.count_out); end
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    take();
    push(4'h4, 1'b1);
    checks++; if (bus.min_out !== 4'h4 || bus.max_out !== 4'h4 || bus.count_out !== 4'd1) begin errors++; $display("FAIL bp_next_frame got=%h/%h/%0d want=4/4/1", bus.min_out, bus.max_out, bus.count_out); end
    take();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      push(4'(i), (i == 19));
      if (i == 14) begin
        checks++; if (bus.count_out !== 4'd15 || bus.cnt_sat !== 1'b0) begin errors++; $display("FAIL sat_at_15 got=%0d/%b want=15/0", bus.count_out, bus.cnt_sat); end
      end
      if (i == 15) begin
        checks++; if (bus.count_out !== 4'd15 || bus.cnt_sat !== 1'b1) begin errors++; $display("FAIL sat_at_16 got=%0d/%b want=15/1", bus.count_out, bus.cnt_sat); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sat_out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.min_out !== 4'h8 || bus.max_out !== 4'h7) begin errors++; $display("FAIL sat_minmax got=%h/%h want=8/7", bus.min_out, bus.max_out); end
    checks++; if (bus.count_out !== 4'd15 || bus.cnt_sat !== 1'b1) begin errors++; $display("FAIL sat_final got=%0d/%b want=15/1", bus.count_out, bus.cnt_sat); end
    take();
    checks++; if (bus.cnt_sat !== 1'b0 || bus.count_out !== 4'd0) begin errors++; $display("FAIL sat_clear got=%0d/%b want=0/0", bus.count_out, bus.cnt_sat); end
  endtask

  task automatic test_reset_midframe();
    push(4'h3, 1'b0); push(4'hF, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_hs got=r%b v%b want=r0 v0", bus.in_ready, bus.out_valid); end
    checks++; if ({bus.min_out, bus.max_out, bus.count_out, bus.cnt_sat} !== 13'h0) begin errors++; $display("FAIL midreset_regs got=%h/%h/%0d/%b want=0/0/0/0", bus.min_out, bus.max_out, bus.count_out, bus.cnt_sat); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(4'h2, 1'b0); push(4'h1, 1'b1);
    checks++; if (bus.min_out !== 4'h1 || bus.max_out !== 4'h2 || bus.count_out !== 4'd2) begin errors++; $display("FAIL midreset_next got=%h/%h/%0d want=1/2/2", bus.min_out, bus.max_out, bus.count_out); end
    take();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mixed();
    test_single();
    test_equal();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
